bus_wrr_scheduler: RTL and testbench

//  Weighted round-robin scheduler between per-terminal source FIFOs and destination FIFOs of the shared bus.

---
 rtl/bus_wrr_scheduler_pkg.sv | 37 +++
 rtl/rr_priority_picker.sv | 27 ++
 rtl/bus_wrr_scheduler.sv | 144 ++++++++++++++
 tb/tb_bus_wrr_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_wrr_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin bus scheduler.
// Destination decode lives here so the top and any future bus variants agree on masks.
package bus_sched_pkg;

  typedef enum logic [2:0] {IDLE, POP, DECODE, WAIT, PUSH} state_e;

  localparam int ID_W      = 8;
  localparam int MAX_DRVRS = 16;

  function automatic int dest_msb(input int pckg_sz);
    return pckg_sz - 1;
  endfunction

  // Zero mask means the destination is invalid and the packet must be dropped.
  function automatic logic [MAX_DRVRS-1:0] dest_mask(
    input logic [ID_W-1:0] dest,
    input logic [3:0]      src,
    input int              drvrs,
    input logic            bcast_en,
    input logic [ID_W-1:0] bcast_id
  );
    logic [MAX_DRVRS-1:0] all_m;
    logic [MAX_DRVRS-1:0] m;
    all_m = '0;
    m     = '0;
    for (int i = 0; i < MAX_DRVRS; i++) begin
      if (i < drvrs) all_m[i] = 1'b1;
    end
    if (bcast_en && (dest == bcast_id)) begin
      m = all_m & ~(MAX_DRVRS'(1) << src);
    end else if ((int'(dest) < drvrs) && (dest != {4'b0000, src})) begin
      m = MAX_DRVRS'(1) << dest;
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request strictly after last_i, wrapping.
// Result is don't-care when no request is set; the caller qualifies it with |req_i.
module rr_priority_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o
);

  always_comb begin
    int   idx;
    logic found;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_i) + off) % N;
      if (!found && req_i[idx]) begin
        winner_o = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin scheduler moving packets from terminal source FIFOs to destination FIFOs.
// Broadcast delivery to all other terminals is enabled by defining WRR_BCAST_EN.
module bus_wrr_scheduler
  import bus_sched_pkg::*;
#(
  parameter  int         bits      = 1,
  parameter  int         drvrs     = 4,
  parameter  int         pckg_sz   = 32,
  parameter  logic [7:0] broadcast = 8'hFF,
  parameter  int         WEIGHT_W  = 4,
  localparam int         IDX_W     = $clog2(drvrs)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  input  logic [drvrs-1:0]         dst_full,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [WEIGHT_W-1:0]      cfg_weight,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     drop
);

  if (bits != 1) begin : g_bits_chk
    $error("bus_wrr_scheduler supports a single bus only");
  end

`ifdef WRR_BCAST_EN
  localparam logic BCAST_EN = 1'b1;
`else
  localparam logic BCAST_EN = 1'b0;
`endif

  localparam int DMSB = dest_msb(pckg_sz);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [drvrs-1:0]     mask_q, mask_d;
  logic [WEIGHT_W-1:0]  weight_q [drvrs];
  logic [IDX_W-1:0]     pick;
  logic [WEIGHT_W-1:0]  pick_w;
  logic [drvrs-1:0]     mask_new;

  rr_priority_picker #(.N(drvrs)) u_picker (
    .req_i    (pndng),
    .last_i   (last_q),
    .winner_o (pick)
  );

  assign pick_w   = weight_q[pick];
  assign mask_new = drvrs'(dest_mask(data_q[DMSB -: ID_W], 4'(grant_q), drvrs, BCAST_EN, broadcast));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    credit_d = credit_q;
    data_d   = data_q;
    mask_d   = mask_q;
    pop      = '0;
    push     = '0;
    D_push   = '0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          // The holder keeps the bus only while it is pending and still has credit.
          if (!(pndng[grant_q] && (credit_q != '0))) begin
            grant_d  = pick;
            last_d   = pick;
            credit_d = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
          end
          state_d = POP;
        end else begin
          credit_d = '0;
        end
      end
      POP: begin
        pop[grant_q] = 1'b1;
        data_d       = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
        state_d      = DECODE;
      end
      DECODE: begin
        if (mask_new != '0) begin
          mask_d  = mask_new;
          state_d = WAIT;
        end else begin
          drop     = 1'b1;
          credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if ((mask_q & dst_full) == '0) state_d = PUSH;
      end
      PUSH: begin
        push     = mask_q;
        D_push   = data_q;
        credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed combinationally so nothing leaks out during the reset cycle.
    if (reset) begin
      pop    = '0;
      push   = '0;
      D_push = '0;
      drop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(drvrs - 1);
      credit_q <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      for (int i = 0; i < drvrs; i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      if (cfg_we && (int'(cfg_idx) < drvrs)) weight_q[cfg_idx] <= cfg_weight;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// Scoreboard bench for bus_wrr_scheduler (drvrs=4, pckg_sz=32); honours WRR_BCAST_EN.
module tb_bus_wrr_scheduler;
  localparam int DRVRS = 4;
  localparam int PSZ   = 32;
  localparam int WW    = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DRVRS-1:0]       pndng, pop, dst_full, push;
  logic [DRVRS*PSZ-1:0]   D_pop;
  logic [PSZ-1:0]         D_push;
  logic                   cfg_we;
  logic [1:0]             cfg_idx;
  logic [WW-1:0]          cfg_weight;
  logic [1:0]             grant_id;
  logic                   busy, drop;

  typedef struct {
    bit          is_drop;
    int          src;
    logic [3:0]  mask;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src_q[DRVRS][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  bus_wrr_scheduler #(
    .bits(1), .drvrs(DRVRS), .pckg_sz(PSZ), .broadcast(8'hFF), .WEIGHT_W(WW)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .dst_full(dst_full), .push(push), .D_push(D_push), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_weight(cfg_weight), .grant_id(grant_id),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic refresh();
    for (int i = 0; i < DRVRS; i++) begin
      pndng[i] = (src_q[i].size() != 0);
      D_pop[i*PSZ +: PSZ] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
    end
  endtask

  task automatic send(input int src, input logic [31:0] data, input bit is_drop, input logic [3:0] mask);
    exp_t e;
    e.is_drop = is_drop;
    e.src     = src;
    e.mask    = mask;
    e.data    = data;
    src_q[src].push_back(data);
    exp_q.push_back(e);
    refresh();
  endtask

  // Source FIFO model: show-ahead, entry leaves just after the popping edge.
  always @(negedge clk) begin
    if (!reset && pop != 0) begin
      int idx;
      idx = 0;
      for (int i = 0; i < DRVRS; i++) if (pop[i]) idx = i;
      @(posedge clk);
      #1;
      if (src_q[idx].size() != 0) void'(src_q[idx].pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pop != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected pop=%b required none", pop);
        end else if (pop !== (4'b0001 << exp_q[0].src) || grant_id !== 2'(exp_q[0].src)) begin
          errors++;
          $display("FAIL pop_grant pop=%b grant_id=%0d required pop=%b grant_id=%0d",
                   pop, grant_id, 4'b0001 << exp_q[0].src, exp_q[0].src);
        end
      end
      if (push != 0 || drop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected push=%b drop=%b required none", push, drop);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_drop) begin
            if (!drop || push != 0) begin
              errors++;
              $display("FAIL drop_event drop=%b push=%b required drop=1 push=0000", drop, push);
            end
          end else if (drop || push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("FAIL push_event push=%b data=%h drop=%b required push=%b data=%h drop=0",
                     push, D_push, drop, e.mask, e.data);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DRVRS; i++) src_q[i].delete();
    refresh();
    dst_full = '0;
    cfg_we   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [WW-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_weight = w;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pop !== 4'b0 || push !== 4'b0 || D_push !== 32'h0 || grant_id !== 2'd0 || busy !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pop=%b push=%b D_push=%h grant=%0d busy=%b drop=%b required all zero",
               pop, push, D_push, grant_id, busy, drop);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_single();
    int t0, tp, tq;
    bit seen;
    apply_reset();
    @(negedge clk);
    send(0, 32'h02AA_0001, 1'b0, 4'b0100);
    t0 = cyc; tp = 0; tq = 0; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pop != 0) begin seen = 1'b1; tp = cyc; end
    end
    checks++;
    if (!seen || tp - t0 != 1) begin
      errors++;
      $display("FAIL single_pop_latency seen=%b latency=%0d required 1", seen, tp - t0);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (push != 0) begin seen = 1'b1; tq = cyc; end
    end
    checks++;
    if (!seen || tq - tp != 3 || push !== 4'b0100 || D_push !== 32'h02AA_0001) begin
      errors++;
      $display("FAIL single_push seen=%b latency=%0d push=%b data=%h required 3 0100 02aa0001",
               seen, tq - tp, push, D_push);
    end
    wait_idle("single");
  endtask

  task automatic test_rotation();
    apply_reset();
    send(0, 32'h0110_0000, 1'b0, 4'b0010);
    send(1, 32'h0211_0000, 1'b0, 4'b0100);
    send(2, 32'h0312_0000, 1'b0, 4'b1000);
    send(3, 32'h0013_0000, 1'b0, 4'b0001);
    send(0, 32'h0110_0001, 1'b0, 4'b0010);
    wait_idle("rotation");
  endtask

  task automatic test_weights();
    apply_reset();
    cfg_write(2'd1, 4'd3);
    cfg_write(2'd2, 4'd0);
    send(0, 32'h0120_0000, 1'b0, 4'b0010);
    send(1, 32'h0021_0000, 1'b0, 4'b0001);
    send(1, 32'h0221_0001, 1'b0, 4'b0100);
    send(1, 32'h0321_0002, 1'b0, 4'b1000);
    send(2, 32'h0022_0000, 1'b0, 4'b0001);
    send(3, 32'h0123_0000, 1'b0, 4'b0010);
    send(1, 32'h0021_0003, 1'b0, 4'b0001);
    send(2, 32'h0122_0001, 1'b0, 4'b0010);
    wait_idle("weights");
  endtask

  task automatic test_wait_full();
    bit seen, bad;
    apply_reset();
    dst_full = 4'b0100;
    send(0, 32'h0255_0000, 1'b0, 4'b0100);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pop != 0) seen = 1'b1;
    end
    repeat (2) @(negedge clk);
    bad = !seen;
    repeat (10) begin
      if (push !== 4'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wait_hold push=%b busy=%b required push=0000 busy=1", push, busy);
    end
    dst_full = 4'b0000;
    @(negedge clk);
    checks++;
    if (push !== 4'b0100 || D_push !== 32'h0255_0000) begin
      errors++;
      $display("FAIL wait_release push=%b data=%h required 0100 02550000", push, D_push);
    end
    wait_idle("wait_full");
  endtask

  task automatic test_drop();
    apply_reset();
    send(1, 32'h0131_0000, 1'b1, 4'b0000);
    send(2, 32'h0032_0000, 1'b0, 4'b0001);
    send(1, 32'h0731_0001, 1'b1, 4'b0000);
    wait_idle("drop");
  endtask

  task automatic test_broadcast();
    apply_reset();
`ifdef WRR_BCAST_EN
    send(3, 32'hFF00_0BCA, 1'b0, 4'b0111);
`else
    send(3, 32'hFF00_0BCA, 1'b1, 4'b0000);
`endif
    wait_idle("broadcast");
  endtask

  task automatic test_reset_in_wait();
    bit seen, pushed;
    apply_reset();
    dst_full = 4'b0001;
    send(1, 32'h0012_3456, 1'b0, 4'b0001);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pop != 0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b1 || push !== 4'b0) begin
      errors++;
      $display("FAIL rst_wait_pre seen=%b busy=%b push=%b required 1 1 0000", seen, busy, push);
    end
    reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (pop !== 4'b0 || push !== 4'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL rst_cycle pop=%b push=%b drop=%b required zero", pop, push, drop);
    end
    @(negedge clk);
    checks++;
    if (pop !== 4'b0 || push !== 4'b0 || D_push !== 32'h0 || grant_id !== 2'd0 || busy !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_post pop=%b push=%b D_push=%h grant=%0d busy=%b drop=%b required all zero",
               pop, push, D_push, grant_id, busy, drop);
    end
    reset    = 1'b0;
    dst_full = 4'b0000;
    pushed   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (push != 0) pushed = 1'b1;
    end
    checks++;
    if (pushed || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_push pushed=%b busy=%b required 0 0", pushed, busy);
    end
  endtask

  initial begin
    reset = 1'b1; pndng = '0; D_pop = '0; dst_full = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
    test_reset();
    test_single();
    test_rotation();
    test_weights();
    test_wait_full();
    test_drop();
    test_broadcast();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
